spi_scan_router: RTL and testbench
==================================

Name: spi_scan_router

Overview:
- Parametrised successor of the 32-way serial scan-chain router. Serially addresses one of NCH downstream channels, then forwards serial data bits to it and returns that channel's serial output.
- Fully synchronous to SCLK. Per-channel clock enables replace the previous gated slave clocks.
- An explicit address/route state machine adds frame-length checking and an error flag.

Parameters:
- NCH, 32, number of downstream channels (2..2**AW).
- AW, 5, address field width in bits. Requires NCH <= 2**AW.

Ports:
- SCLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous reset, active-high.
- REGSEL  in  1  1 = address phase, 0 = data phase.
- SIN  in  1  serial input bit.
- SIN_VLD  in  1  bit strobe; SIN/REGSEL sampled only when high.
- MIN  in  NCH  serial return bit from each channel.
- S_SCLK  out  NCH  per-channel one-cycle bit strobe (clock enable).
- MOUT  out  NCH  per-channel forwarded data bit.
- SOUT  out  1  serial return from the selected channel.
- SEL  out  AW  committed channel address.
- BUSY  out  1  high while in ROUTE.
- ERR  out  1  sticky frame/address error.

Behaviour:
- Reset (RESET=1 at an edge, any state including mid-frame):
  - state=IDLE; shift register, bit counter, SEL, S_SCLK, MOUT, SOUT, BUSY and ERR all cleared to 0.
- States are IDLE, ADDR and ROUTE. All outputs are registered.
- IDLE:
  - SIN_VLD & REGSEL: go to ADDR, shift SIN into the LSB, set count=1.
  - SIN_VLD & ~REGSEL: ignored; no output activity.
- ADDR, on SIN_VLD & REGSEL:
  - Shift MSB-first: shreg <= {shreg[AW-2:0], SIN}; count++.
  - Commit occurs on the edge that samples the AW-th bit: SEL <= {shreg, SIN}.
  - If the committed value < NCH: go to ROUTE and set BUSY=1.
  - Otherwise: set ERR=1 and go to IDLE; SEL still updates.
- ADDR, on SIN_VLD & ~REGSEL before AW bits have been received (short frame):
  - Set ERR=1, go to IDLE, leave SEL unchanged, clear count.
- SIN_VLD low in ADDR: hold state; there is no timeout.
- ROUTE, on SIN_VLD & ~REGSEL:
  - Next edge: S_SCLK[SEL]=1 for exactly one cycle; MOUT[SEL]=SIN; all other S_SCLK/MOUT bits 0.
  - MOUT[SEL] holds its value until the next strobe or until ROUTE is exited.
- ROUTE, SOUT:
  - SOUT <= MIN[SEL] every cycle (1-cycle latency).
  - SOUT=0 in IDLE and ADDR.
- ROUTE, on SIN_VLD & REGSEL (re-address):
  - Go to ADDR with count=1, SIN shifted in, BUSY=0.
  - S_SCLK and MOUT clear next cycle; SEL keeps its old value until the new commit.
- Latency: 1 SCLK cycle from the strobe edge to S_SCLK/MOUT/SEL/BUSY update.
- Back-to-back strobes on consecutive cycles are legal; each one produces its own S_SCLK pulse.
- ERR is cleared only by RESET. It does not block subsequent valid frames.

Optional Feature:
- Macro SPI_SCAN_ROUTER_BCAST_EN.
- Defined:
  - Address frame is AW+1 bits, with a leading broadcast flag bit followed by AW address bits.
  - Flag=1: the address bits are ignored (no range check), ROUTE is entered in broadcast mode, and SEL reports the received bits.
  - In broadcast mode each data strobe pulses all NCH S_SCLK bits and drives SIN onto all MOUT bits; SOUT is held 0.
  - Flag=0 behaves exactly as the non-broadcast case.
- Undefined:
  - Frame is AW bits; no broadcast mode exists.

Test Plan:
1. Assert RESET 2 cycles, including once mid-ROUTE after a valid frame → next cycle: S_SCLK=0, MOUT=0, SOUT=0, SEL=0, BUSY=0, ERR=0, state=IDLE.
2. NCH=32: address bits 0,0,1,0,1 (REGSEL=1), then data 1,0,1 (REGSEL=0) → SEL=5, BUSY=1; S_SCLK=32'h20 pulses 3 times, each 1 cycle after its strobe; MOUT[5]=1,0,1; all other bits 0.
3. In ROUTE with SEL=5: MIN=32'h0000_0020 → SOUT=1 next cycle; MIN=32'hFFFF_FFDF → SOUT=0.
4. NCH=20 instance: address 5'd25 → ERR=1, BUSY=0, state IDLE; following data strobes produce S_SCLK=0.
5. With SEL=5 committed: send 3 address bits, then one strobe with REGSEL=0 → ERR=1, state IDLE, SEL stays 5.
6. SPI_SCAN_ROUTER_BCAST_EN defined: frame 1,0,0,0,0,0 then data bit 1 → S_SCLK=32'hFFFF_FFFF for 1 cycle, MOUT=32'hFFFF_FFFF, SOUT=0.

Source files
------------

// File: rtl/spi_scan_router.sv
// Serial scan-chain router: MSB-first address frame selects one of NCH channels, then data
// strobes are forwarded as per-channel clock enables. Optional broadcast: SPI_SCAN_ROUTER_BCAST_EN.

module spi_scan_router_lane (
    input  logic SCLK,
    input  logic RESET,
    input  logic hit,
    input  logic clr,
    input  logic sin,
    output logic s_sclk,
    output logic mout
);
    always_ff @(posedge SCLK) begin
        if (RESET) begin
            s_sclk <= 1'b0;
            mout   <= 1'b0;
        end else begin
            s_sclk <= hit;
            if (clr)
                mout <= 1'b0;
            else if (hit)
                mout <= sin;
        end
    end
endmodule

module spi_scan_router #(
    parameter int NCH = 32,
    parameter int AW  = 5
) (
    input  logic           SCLK,
    input  logic           RESET,
    input  logic           REGSEL,
    input  logic           SIN,
    input  logic           SIN_VLD,
    input  logic [NCH-1:0] MIN,
    output logic [NCH-1:0] S_SCLK,
    output logic [NCH-1:0] MOUT,
    output logic           SOUT,
    output logic [AW-1:0]  SEL,
    output logic           BUSY,
    output logic           ERR
);
`ifdef SPI_SCAN_ROUTER_BCAST_EN
    localparam int FW = AW + 1;
`else
    localparam int FW = AW;
`endif
    localparam int CW = $clog2(FW + 1);

    typedef enum logic [1:0] {IDLE, ADDR, ROUTE} state_t;

    state_t          state, state_n;
    logic [FW-1:0]   shreg, shreg_n, shreg_base, shreg_sh;
    logic [CW-1:0]   cnt, cnt_n, cnt_base, cnt_inc;
    logic [AW-1:0]   sel_n, frame_addr;
    logic            bcast_q, bcast_n, err_n;
    logic            frame_flag, in_range, addr_bit, data_bit, data_stb;
    logic [NCH-1:0]  sel_hit_n, lane_hit;

    assign addr_bit   = SIN_VLD & REGSEL;
    assign data_bit   = SIN_VLD & ~REGSEL;
    // A frame restarts from empty whenever an address bit arrives outside ADDR.
    assign shreg_base = (state == ADDR) ? shreg : '0;
    assign cnt_base   = (state == ADDR) ? cnt : '0;
    assign shreg_sh   = (shreg_base << 1) | FW'(SIN);
    assign cnt_inc    = cnt_base + CW'(1);
    assign frame_addr = shreg_sh[AW-1:0];
`ifdef SPI_SCAN_ROUTER_BCAST_EN
    assign frame_flag = shreg_sh[AW];
`else
    assign frame_flag = 1'b0;
`endif
    assign in_range   = {1'b0, frame_addr} < (AW+1)'(NCH);

    always_ff @(posedge SCLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        cnt_n    = cnt;
        sel_n    = SEL;
        bcast_n  = bcast_q;
        err_n    = ERR;
        data_stb = 1'b0;
        case (state)
            IDLE, ROUTE: begin
                if (addr_bit) begin
                    state_n = ADDR;
                    shreg_n = shreg_sh;
                    cnt_n   = cnt_inc;
                    bcast_n = 1'b0;
                end else if (data_bit && state == ROUTE) begin
                    data_stb = 1'b1;
                end
            end
            ADDR: begin
                if (addr_bit) begin
                    state_n = ADDR;
                    shreg_n = shreg_sh;
                    cnt_n   = cnt_inc;
                end else if (data_bit) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        // Commit on the bit that completes the frame, whichever state it arrived in.
        if (addr_bit && cnt_inc == CW'(FW)) begin
            sel_n = frame_addr;
            cnt_n = '0;
            if (frame_flag) begin
                state_n = ROUTE;
                bcast_n = 1'b1;
            end else if (in_range) begin
                state_n = ROUTE;
                bcast_n = 1'b0;
            end else begin
                state_n = IDLE;
                err_n   = 1'b1;
            end
        end
    end

    always_ff @(posedge SCLK) begin
        if (RESET) begin
            shreg   <= '0;
            cnt     <= '0;
            SEL     <= '0;
            bcast_q <= 1'b0;
            BUSY    <= 1'b0;
            ERR     <= 1'b0;
            SOUT    <= 1'b0;
        end else begin
            shreg   <= shreg_n;
            cnt     <= cnt_n;
            SEL     <= sel_n;
            bcast_q <= bcast_n;
            BUSY    <= (state_n == ROUTE);
            ERR     <= err_n;
            SOUT    <= (state_n == ROUTE) & ~bcast_n & |(MIN & sel_hit_n);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign sel_hit_n[i] = (sel_n == AW'(i));
        assign lane_hit[i]  = data_stb & (bcast_q | (SEL == AW'(i)));
        spi_scan_router_lane u_lane (
            .SCLK   (SCLK),
            .RESET  (RESET),
            .hit    (lane_hit[i]),
            .clr    (state_n != ROUTE),
            .sin    (SIN),
            .s_sclk (S_SCLK[i]),
            .mout   (MOUT[i])
        );
    end
endmodule

// File: tb/tb_spi_scan_router.sv
// Directed vectors for spi_scan_router: a 32-channel instance for routing and a 20-channel
// instance for range checking, both driven from the same serial inputs.

module tb_spi_scan_router;
    localparam int AW = 5;

    logic        SCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REGSEL = 1'b0;
    logic        SIN = 1'b0;
    logic        SIN_VLD = 1'b0;
    logic [31:0] MIN = '0;

    logic [31:0] s_sclk, mout;
    logic        sout, busy, err;
    logic [4:0]  sel;
    logic [19:0] s_sclk20, mout20;
    logic        sout20, busy20, err20;
    logic [4:0]  sel20;

    int n_pass = 0;
    int n_total = 0;

    spi_scan_router #(.NCH(32), .AW(AW)) dut (
        .SCLK(SCLK), .RESET(RESET), .REGSEL(REGSEL), .SIN(SIN), .SIN_VLD(SIN_VLD),
        .MIN(MIN), .S_SCLK(s_sclk), .MOUT(mout), .SOUT(sout), .SEL(sel),
        .BUSY(busy), .ERR(err)
    );

    spi_scan_router #(.NCH(20), .AW(AW)) dut20 (
        .SCLK(SCLK), .RESET(RESET), .REGSEL(REGSEL), .SIN(SIN), .SIN_VLD(SIN_VLD),
        .MIN(MIN[19:0]), .S_SCLK(s_sclk20), .MOUT(mout20), .SOUT(sout20), .SEL(sel20),
        .BUSY(busy20), .ERR(err20)
    );

    always #5 SCLK = ~SCLK;

    typedef struct {
        logic        first;
        logic        rs, sin, vld;
        logic [31:0] min;
        logic [31:0] es, em;
        logic        esout;
        logic [4:0]  esel;
        logic        ebusy, eerr;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic rs, input logic s, input logic v, input logic [31:0] m);
        @(negedge SCLK);
        REGSEL = rs; SIN = s; SIN_VLD = v; MIN = m;
        @(posedge SCLK);
        #1;
    endtask

    task automatic send_frame(input int unsigned a, input logic flag);
`ifdef SPI_SCAN_ROUTER_BCAST_EN
        drive(1'b1, flag, 1'b1, MIN);
`else
        if (flag) $display("note: broadcast flag ignored in this build");
`endif
        for (int i = AW - 1; i >= 0; i--)
            drive(1'b1, a[i], 1'b1, MIN);
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk({tag, " s_sclk"}, s_sclk, v.es);
        chk({tag, " mout"}, mout, v.em);
        chk({tag, " sout"}, 32'(sout), 32'(v.esout));
        chk({tag, " sel"}, 32'(sel), 32'(v.esel));
        chk({tag, " busy"}, 32'(busy), 32'(v.ebusy));
        chk({tag, " err"}, 32'(err), 32'(v.eerr));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " s_sclk"}, s_sclk, 32'h0);
        chk({tag, " mout"}, mout, 32'h0);
        chk({tag, " sout"}, 32'(sout), 32'h0);
        chk({tag, " sel"}, 32'(sel), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " err"}, 32'(err), 32'h0);
        chk({tag, " s_sclk20"}, 32'(s_sclk20), 32'h0);
        chk({tag, " err20"}, 32'(err20), 32'h0);
    endtask

    initial begin
        //            first rs sin vld min           s_sclk        mout          sout sel busy err
        tv.push_back('{1'b1, 1, 0, 1, 32'h0,        32'h0,        32'h0,        0, 5'd0,  0, 0});
        tv.push_back('{1'b0, 1, 0, 1, 32'h0,        32'h0,        32'h0,        0, 5'd0,  0, 0});
        tv.push_back('{1'b0, 1, 1, 1, 32'h0,        32'h0,        32'h0,        0, 5'd0,  0, 0});
        tv.push_back('{1'b0, 1, 0, 1, 32'h0,        32'h0,        32'h0,        0, 5'd0,  0, 0});
        tv.push_back('{1'b0, 1, 1, 1, 32'h0,        32'h0,        32'h0,        0, 5'd5,  1, 0});
        tv.push_back('{1'b0, 0, 1, 1, 32'h0,        32'h20,       32'h20,       0, 5'd5,  1, 0});
        tv.push_back('{1'b0, 0, 0, 0, 32'h0,        32'h0,        32'h20,       0, 5'd5,  1, 0});
        tv.push_back('{1'b0, 0, 0, 1, 32'h0,        32'h20,       32'h0,        0, 5'd5,  1, 0});
        tv.push_back('{1'b0, 0, 1, 1, 32'h0,        32'h20,       32'h20,       0, 5'd5,  1, 0});
        tv.push_back('{1'b0, 0, 0, 0, 32'h20,       32'h0,        32'h20,       1, 5'd5,  1, 0});
        tv.push_back('{1'b0, 0, 0, 0, 32'hFFFFFFDF, 32'h0,        32'h20,       0, 5'd5,  1, 0});
        tv.push_back('{1'b0, 0, 0, 1, 32'hFFFFFFFF, 32'h20,       32'h0,        1, 5'd5,  1, 0});
        tv.push_back('{1'b1, 1, 0, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 5'd5,  0, 0});
        tv.push_back('{1'b0, 1, 0, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 5'd5,  0, 0});
        tv.push_back('{1'b0, 1, 1, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 5'd5,  0, 0});
        tv.push_back('{1'b0, 0, 1, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 5'd5,  0, 1});
        tv.push_back('{1'b0, 0, 1, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 5'd5,  0, 1});
        tv.push_back('{1'b1, 1, 1, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 5'd5,  0, 1});
        tv.push_back('{1'b0, 1, 1, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 5'd5,  0, 1});
        tv.push_back('{1'b0, 1, 1, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 5'd5,  0, 1});
        tv.push_back('{1'b0, 1, 1, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 5'd5,  0, 1});
        tv.push_back('{1'b0, 1, 1, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 5'd31, 1, 1});
        tv.push_back('{1'b0, 0, 1, 1, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 1, 5'd31, 1, 1});
        tv.push_back('{1'b0, 0, 0, 1, 32'h0,        32'h80000000, 32'h0,        0, 5'd31, 1, 1});

        // Reset held for two cycles with traffic on the inputs.
        RESET = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF);
        drive(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
        chk_zero("reset");
        RESET = 1'b0;

        foreach (tv[i]) begin
`ifdef SPI_SCAN_ROUTER_BCAST_EN
            // Leading broadcast flag (0) ahead of each address frame.
            if (tv[i].first) begin
                drive(tv[i].rs, 1'b0, tv[i].vld, tv[i].min);
                chk_vec($sformatf("v%0d flag", i), tv[i]);
            end
`endif
            drive(tv[i].rs, tv[i].sin, tv[i].vld, tv[i].min);
            chk_vec($sformatf("v%0d", i), tv[i]);
        end

        // Reset in the middle of ROUTE.
        drive(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
        chk("pre-reset mout", mout, 32'h80000000);
        chk("pre-reset sout", 32'(sout), 32'h1);
        RESET = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
        drive(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
        chk_zero("mid-route reset");
        RESET = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
        chk("idle data s_sclk", s_sclk, 32'h0);
        chk("idle data busy", 32'(busy), 32'h0);
        chk("idle data sout", 32'(sout), 32'h0);

        // Out-of-range address on the 20-channel instance, in range on the 32-channel one.
        send_frame(25, 1'b0);
        chk("oor err20", 32'(err20), 32'h1);
        chk("oor busy20", 32'(busy20), 32'h0);
        chk("oor sel20", 32'(sel20), 32'd25);
        chk("oor busy", 32'(busy), 32'h1);
        chk("oor err", 32'(err), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h0);
        chk("oor s_sclk20", 32'(s_sclk20), 32'h0);
        chk("oor mout20", 32'(mout20), 32'h0);
        chk("oor s_sclk", s_sclk, 32'h02000000);

        // Highest legal channel on the 20-channel instance.
        send_frame(19, 1'b0);
        chk("top busy20", 32'(busy20), 32'h1);
        chk("top sel20", 32'(sel20), 32'd19);
        drive(1'b0, 1'b1, 1'b1, 32'h0);
        chk("top s_sclk20", 32'(s_sclk20), 32'h80000);
        chk("top mout20", 32'(mout20), 32'h80000);
        drive(1'b0, 1'b0, 1'b0, 32'h00080000);
        chk("top s_sclk20 drop", 32'(s_sclk20), 32'h0);
        chk("top sout20", 32'(sout20), 32'h1);

`ifdef SPI_SCAN_ROUTER_BCAST_EN
        send_frame(0, 1'b1);
        chk("bcast busy", 32'(busy), 32'h1);
        chk("bcast sel", 32'(sel), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
        chk("bcast s_sclk", s_sclk, 32'hFFFFFFFF);
        chk("bcast mout", mout, 32'hFFFFFFFF);
        chk("bcast sout", 32'(sout), 32'h0);
        chk("bcast s_sclk20", 32'(s_sclk20), 32'h000FFFFF);
        drive(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);
        chk("bcast s_sclk drop", s_sclk, 32'h0);
        chk("bcast mout hold", mout, 32'hFFFFFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
